clk_div_n: RTL and testbench

- Runtime-programmable integer clock divider: generates oclk = sclk / N with 50 % duty for both even and odd N.
- Odd ratios are built from a posedge-generated phase ORed with a negedge-delayed copy.
- Ratio changes and enable/disable take effect only at period boundaries, so oclk never glitches or produces runt pulses.
- Sits in the clocking area; feeds low-speed peripherals and divided strobes.

---
 rtl/clk_div_n.sv | 127 ++++++++++++
 tb/tb_clk_div_n.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_n.sv
// Runtime-programmable integer clock divider with 50% duty for even and odd ratios.
// Ratio and enable changes are applied only at period boundaries, so oclk never glitches.
module clk_div_n #(
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned DIV_RST = 5
) (
   input  logic             sclk,
   input  logic             s_rst_n,
   input  logic             en,
   input  logic [CNT_W-1:0] div_in,
   input  logic             div_load,
   output logic             oclk,
   output logic             period_start,
   output logic [CNT_W-1:0] div_cur,
   output logic             load_pend
);

   localparam logic [CNT_W-1:0] DIV_MIN   = CNT_W'(2);
   localparam logic [CNT_W-1:0] DIV_RST_V = CNT_W'(DIV_RST);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] shadow;
   logic [CNT_W-1:0] shadow_nxt;
   logic [CNT_W-1:0] div_cur_nxt;
   logic [CNT_W-1:0] div_in_clamp;
   logic [CNT_W-1:0] half_nxt;
   logic             p_clk;
   logic             p_clk_nxt;
   logic             period_start_nxt;
   logic             load_pend_nxt;
   logic             boundary;
   logic             apply;
   logic             n_clk;
   logic             odd_n;

   // Posedge state register
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         p_clk        <= 1'b0;
         period_start <= 1'b0;
         div_cur      <= DIV_RST_V;
         shadow       <= DIV_RST_V;
         load_pend    <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         p_clk        <= p_clk_nxt;
         period_start <= period_start_nxt;
         div_cur      <= div_cur_nxt;
         shadow       <= shadow_nxt;
         load_pend    <= load_pend_nxt;
      end
   end

   // Next-state: period sequencing, shadow handoff and high-phase decode
   always_comb begin
      state_nxt        = state;
      cnt_nxt          = cnt;
      period_start_nxt = 1'b0;
      div_cur_nxt      = div_cur;
      shadow_nxt       = shadow;
      load_pend_nxt    = load_pend;
      div_in_clamp     = (div_in < DIV_MIN) ? DIV_MIN : div_in;
      boundary         = (state == RUN) && (cnt == (div_cur - CNT_W'(1)));
      apply            = boundary || ((state == IDLE) && en);

      // Pending ratio takes over as a new period is entered; a same-edge load stays pending
      if (apply && load_pend) begin
         div_cur_nxt   = shadow;
         load_pend_nxt = 1'b0;
      end
      if (div_load) begin
         shadow_nxt    = div_in_clamp;
         load_pend_nxt = 1'b1;
      end

      case (state)
         IDLE: begin
            if (en) begin
               state_nxt        = RUN;
               cnt_nxt          = '0;
               period_start_nxt = 1'b1;
            end
         end
         RUN: begin
            if (boundary) begin
               cnt_nxt = '0;
               if (en) begin
                  period_start_nxt = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase

      half_nxt  = div_cur_nxt >> 1;
      p_clk_nxt = (state_nxt == RUN) && (cnt_nxt < half_nxt);
   end

   // Half-cycle delayed copy stretches the high phase by half a cycle for odd ratios
   always_ff @(negedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         n_clk <= 1'b0;
         odd_n <= 1'b0;
      end else begin
         n_clk <= p_clk;
         odd_n <= div_cur[0];
      end
   end

   assign oclk = p_clk | (n_clk & odd_n);

endmodule

// File: tb/tb_clk_div_n.sv
// Self-checking bench for clk_div_n: per-period high/low widths measured from oclk edge
// times are checked against a queue of expected periods pushed by the stimulus.
`timescale 1ns/1ps
module tb_clk_div_n;

   localparam int unsigned CNT_W = 8;

   logic             sclk;
   logic             s_rst_n;
   logic             en;
   logic [CNT_W-1:0] div_in;
   logic             div_load;
   logic             oclk;
   logic             period_start;
   logic [CNT_W-1:0] div_cur;
   logic             load_pend;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int hi;
      int lo;
   } per_t;

   typedef struct {
      logic [CNT_W-1:0] div_in;
      logic [CNT_W-1:0] exp_div;
      int               exp_hi;
      int               exp_lo;
   } vec_t;

   per_t exp_q[$];
   per_t mon_e;
   time  t_rise = 0;
   time  t_fall = 0;

   clk_div_n #(.CNT_W(CNT_W), .DIV_RST(5)) dut (
      .sclk         (sclk),
      .s_rst_n      (s_rst_n),
      .en           (en),
      .div_in       (div_in),
      .div_load     (div_load),
      .oclk         (oclk),
      .period_start (period_start),
      .div_cur      (div_cur),
      .load_pend    (load_pend)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // A rising oclk edge closes one full period: compare its widths with the next expectation
   always @(oclk) begin
      if (oclk === 1'b1) begin
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("period_hi_ns", 32'(int'(t_fall - t_rise)), 32'(mon_e.hi));
            chk("period_lo_ns", 32'(int'($time - t_fall)), 32'(mon_e.lo));
         end
         t_rise = $time;
      end else begin
         t_fall = $time;
      end
   end

   task automatic push_exp(input int hi, input int lo, input int k);
      per_t e;
      e.hi = hi;
      e.lo = lo;
      for (int i = 0; i < k; i++) exp_q.push_back(e);
   endtask

   task automatic wait_drain(input int budget);
      int c;
      c = 0;
      while (exp_q.size() != 0 && c < budget) begin
         @(posedge sclk);
         c++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic load_div(input logic [CNT_W-1:0] v);
      @(negedge sclk);
      div_in   = v;
      div_load = 1'b1;
      @(negedge sclk);
      div_load = 1'b0;
   endtask

   // Leaves the bench at #1 after the boundary edge that consumed the pending load
   task automatic wait_pend_clear(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(posedge sclk);
         #1;
         if (!load_pend) begin
            done = 1'b1;
            break;
         end
      end
      chk(name, 32'(done), 32'd1);
   endtask

   vec_t vecs[7];
   bit   bad;
   int   gap;

   initial begin
      vecs[0] = '{8'd4,   8'd4,   20,   20};
      vecs[1] = '{8'd3,   8'd3,   15,   15};
      vecs[2] = '{8'd2,   8'd2,   10,   10};
      vecs[3] = '{8'd0,   8'd2,   10,   10};
      vecs[4] = '{8'd1,   8'd2,   10,   10};
      vecs[5] = '{8'd255, 8'd255, 1275, 1275};
      vecs[6] = '{8'd5,   8'd5,   25,   25};

      s_rst_n  = 1'b0;
      en       = 1'b0;
      div_in   = '0;
      div_load = 1'b0;

      #12;
      chk("rst_oclk", 32'(oclk), 32'd0);
      chk("rst_period_start", 32'(period_start), 32'd0);
      chk("rst_div_cur", 32'(div_cur), 32'd5);
      chk("rst_load_pend", 32'(load_pend), 32'd0);
      @(negedge sclk);
      s_rst_n = 1'b1;

      repeat (3) @(posedge sclk);
      #1;
      chk("idle_oclk", 32'(oclk), 32'd0);

      // First enable: oclk rises on the edge that samples en
      @(negedge sclk);
      en = 1'b1;
      @(posedge sclk);
      #1;
      chk("start_oclk", 32'(oclk), 32'd1);
      chk("start_period_start", 32'(period_start), 32'd1);
      chk("start_div_cur", 32'(div_cur), 32'd5);
      gap = 0;
      do begin
         @(posedge sclk);
         #1;
         gap++;
      end while (!period_start && gap < 20);
      chk("period_start_spacing", 32'(gap), 32'd5);
      push_exp(25, 25, 2);
      wait_drain(200);

      // Ratio table: each load lands on the next boundary, then two periods are measured
      for (int i = 0; i < 7; i++) begin
         load_div(vecs[i].div_in);
         chk("load_pend_set", 32'(load_pend), 32'd1);
         wait_pend_clear("load_pend_clear");
         chk("vec_div_cur", 32'(div_cur), 32'(vecs[i].exp_div));
         chk("vec_period_start", 32'(period_start), 32'd1);
         push_exp(vecs[i].exp_hi, vecs[i].exp_lo, 2);
         wait_drain(1000);
      end

      // N=7 running; loads of 6 at cnt=2 and 9 at cnt=4: old period completes, 9 wins
      load_div(8'd7);
      wait_pend_clear("n7_pend_clear");
      chk("n7_div_cur", 32'(div_cur), 32'd7);
      push_exp(35, 35, 1);
      push_exp(45, 45, 1);
      repeat (2) @(posedge sclk);
      @(negedge sclk);
      div_in   = 8'd6;
      div_load = 1'b1;
      @(posedge sclk);
      @(negedge sclk);
      div_load = 1'b0;
      chk("n7_pend_after_6", 32'(load_pend), 32'd1);
      chk("n7_div_hold", 32'(div_cur), 32'd7);
      @(posedge sclk);
      @(negedge sclk);
      div_in   = 8'd9;
      div_load = 1'b1;
      @(posedge sclk);
      @(negedge sclk);
      div_load = 1'b0;
      repeat (2) @(posedge sclk);
      #1;
      chk("n9_div_cur", 32'(div_cur), 32'd9);
      chk("n9_load_pend", 32'(load_pend), 32'd0);
      chk("n9_period_start", 32'(period_start), 32'd1);
      wait_drain(200);

      // en dropped at cnt=1 with N=5: period completes, then quiet until re-enable
      load_div(8'd5);
      wait_pend_clear("en_pend_clear");
      @(posedge sclk);
      @(negedge sclk);
      en = 1'b0;
      @(posedge sclk);
      #1;
      chk("en_off_still_high", 32'(oclk), 32'd1);
      repeat (3) @(posedge sclk);
      #1;
      chk("en_off_oclk", 32'(oclk), 32'd0);
      chk("en_off_period_start", 32'(period_start), 32'd0);
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge sclk);
         #1;
         if (oclk !== 1'b0 || period_start !== 1'b0) bad = 1'b1;
         @(posedge sclk);
         #1;
         if (oclk !== 1'b0 || period_start !== 1'b0) bad = 1'b1;
      end
      chk("idle_quiet", 32'(bad), 32'd0);
      @(negedge sclk);
      en = 1'b1;
      @(posedge sclk);
      #1;
      chk("reen_oclk", 32'(oclk), 32'd1);
      chk("reen_period_start", 32'(period_start), 32'd1);
      push_exp(25, 25, 2);
      wait_drain(200);

      // Reset while oclk high with a load pending: drops at once, pending load discarded
      @(negedge sclk);
      div_in   = 8'd3;
      div_load = 1'b1;
      @(posedge sclk);
      #1;
      div_load = 1'b0;
      while (!(oclk === 1'b1 && load_pend === 1'b1 && period_start === 1'b0) && gap < 100) begin
         @(posedge sclk);
         #1;
         gap++;
      end
      chk("pre_rst_oclk", 32'(oclk), 32'd1);
      #2;
      s_rst_n = 1'b0;
      #1;
      chk("mid_rst_oclk", 32'(oclk), 32'd0);
      chk("mid_rst_div_cur", 32'(div_cur), 32'd5);
      chk("mid_rst_load_pend", 32'(load_pend), 32'd0);
      chk("mid_rst_period_start", 32'(period_start), 32'd0);
      repeat (2) @(posedge sclk);
      @(negedge sclk);
      s_rst_n = 1'b1;
      @(posedge sclk);
      #1;
      chk("post_rst_oclk", 32'(oclk), 32'd1);
      chk("post_rst_period_start", 32'(period_start), 32'd1);
      chk("post_rst_div_cur", 32'(div_cur), 32'd5);
      push_exp(25, 25, 2);
      wait_drain(200);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
